// File: rtl/uart_tx.sv
// UART transmitter that pulls bytes from a synchronous FIFO's read side and
// shifts them out as 1 start bit, DBITS data bits (LSB first), optional parity and 1-2 stop bits.
module uart_tx #(
    parameter int CLKDIV   = 434,
    parameter int DBITS    = 8,
    parameter int PARITY   = 0,
    parameter int STOPBITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fifo_empty,
    input  logic [DBITS-1:0] fifo_data,
    output logic             fifo_pop,
    input  logic             cts_n,
    output logic             txd,
    output logic             busy,
    output logic [2:0]       dbg_state_o
);

    localparam int             BW        = $clog2(CLKDIV);
    localparam logic [BW-1:0]  BCNT_LOAD = BW'(CLKDIV - 1);
    localparam logic [2:0]     LAST_DBIT = 3'(DBITS - 1);
    localparam logic [2:0]     LAST_SBIT = 3'(STOPBITS - 1);
    localparam logic           ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic [2:0]         nbit_q, nbit_d;
    logic [DBITS-1:0]   shreg_q, shreg_d;
    logic               par_q, par_d;
    logic               txd_q, txd_d;
    logic               launch;
    logic               bit_done;
    logic               start_frame;

    always_comb begin
        // Reset also blocks a pop so no byte is taken from the FIFO and then discarded.
        launch      = !fifo_empty && !cts_n && !rst_i;
        bit_done    = (bcnt_q == '0);
        start_frame = 1'b0;
        fifo_pop    = 1'b0;
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        nbit_d      = nbit_q;
        shreg_d     = shreg_q;
        par_d       = par_q;

        if (state_q != IDLE) begin
            bcnt_d = bcnt_q - BW'(1);
        end

        case (state_q)
            IDLE: begin
                start_frame = launch;
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    bcnt_d  = BCNT_LOAD;
                    nbit_d  = 3'd0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shreg_d = shreg_q >> 1;
                    bcnt_d  = BCNT_LOAD;
                    if (nbit_q == LAST_DBIT) begin
                        nbit_d  = 3'd0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        nbit_d = nbit_q + 3'd1;
                    end
                end
            end
            PAR: begin
                if (bit_done) begin
                    state_d = STOP;
                    bcnt_d  = BCNT_LOAD;
                    nbit_d  = 3'd0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    bcnt_d = BCNT_LOAD;
                    if (nbit_q == LAST_SBIT) begin
                        // Chain straight into the next frame when another byte is ready.
                        start_frame = launch;
                        state_d     = IDLE;
                        nbit_d      = 3'd0;
                    end else begin
                        nbit_d = nbit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_frame) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_data;
            par_d    = (^fifo_data) ^ ODD_PAR;
            state_d  = START;
            bcnt_d   = BCNT_LOAD;
            nbit_d   = 3'd0;
        end

        // The line level is registered from the next state so txd never glitches.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
            PAR:     txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            nbit_q  <= 3'd0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            nbit_q  <= nbit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    assign txd         = txd_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations share one clock and reset, each fed by its own
// FIFO model; a frame-level reference predicts txd, busy and fifo_pop every cycle.
module tb_uart_tx;

    localparam int CLKDIV = 4;
    localparam int NCH    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   fifo_empty;
    logic [7:0]       fifo_data [NCH];
    logic [NCH-1:0]   fifo_pop;
    logic [NCH-1:0]   cts_n = '0;
    logic [NCH-1:0]   txd;
    logic [NCH-1:0]   busy;
    logic [2:0]       dbg_state [NCH];

    logic [7:0] fifo_mem [NCH][256];
    logic [7:0] head [NCH] = '{default: 8'd0};
    logic [7:0] tail [NCH] = '{default: 8'd0};

    int         rem      [NCH] = '{default: 0};
    logic [7:0] cur_byte [NCH] = '{default: 8'd0};
    logic [NCH-1:0] e_pop, e_busy, e_txd;

    bit chk_en = 1'b0;
    int n_vec  = 0;
    int n_err  = 0;

    always #5 clk = ~clk;

    // channel 0: no parity, 1 stop; channel 1: even parity; channel 2: odd parity, 2 stops
    uart_tx #(.CLKDIV(CLKDIV), .DBITS(8), .PARITY(0), .STOPBITS(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]),
        .fifo_pop(fifo_pop[0]), .cts_n(cts_n[0]), .txd(txd[0]), .busy(busy[0]),
        .dbg_state_o(dbg_state[0]));
    uart_tx #(.CLKDIV(CLKDIV), .DBITS(8), .PARITY(1), .STOPBITS(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]),
        .fifo_pop(fifo_pop[1]), .cts_n(cts_n[1]), .txd(txd[1]), .busy(busy[1]),
        .dbg_state_o(dbg_state[1]));
    uart_tx #(.CLKDIV(CLKDIV), .DBITS(8), .PARITY(2), .STOPBITS(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .fifo_empty(fifo_empty[2]), .fifo_data(fifo_data[2]),
        .fifo_pop(fifo_pop[2]), .cts_n(cts_n[2]), .txd(txd[2]), .busy(busy[2]),
        .dbg_state_o(dbg_state[2]));

    function automatic int par_cfg(int c);
        return (c == 0) ? 0 : ((c == 1) ? 1 : 2);
    endfunction

    function automatic int stop_cfg(int c);
        return (c == 2) ? 2 : 1;
    endfunction

    function automatic int flen(int c);
        return (1 + 8 + ((par_cfg(c) != 0) ? 1 : 0) + stop_cfg(c)) * CLKDIV;
    endfunction

    // Line level idx cycles into a frame: start, data LSB first, parity, then stop bits.
    function automatic logic frame_level(int c, logic [7:0] b, int idx);
        int bitpos;
        bitpos = idx / CLKDIV;
        if (bitpos == 0) return 1'b0;
        if (bitpos <= 8) return b[bitpos-1];
        if (par_cfg(c) != 0 && bitpos == 9) return (^b) ^ (par_cfg(c) == 2);
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            fifo_empty[c] = (head[c] == tail[c]);
            fifo_data[c]  = fifo_mem[c][head[c]];
            e_busy[c]     = (rem[c] > 0);
            e_txd[c]      = (rem[c] > 0) ? frame_level(c, cur_byte[c], flen(c) - rem[c]) : 1'b1;
            e_pop[c]      = !fifo_empty[c] && !cts_n[c] && !rst && (rem[c] <= 1);
        end
    end

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (fifo_pop[c] && head[c] != tail[c]) head[c] <= head[c] + 8'd1;
        end
    end

    // Reference: a frame occupies exactly flen cycles after the pop; a new pop may only
    // happen while idle or in the last frame cycle.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (chk_en) begin
                check($sformatf("txd%0d", c), 32'(txd[c]), 32'(e_txd[c]));
                check($sformatf("busy%0d", c), 32'(busy[c]), 32'(e_busy[c]));
                check($sformatf("pop%0d", c), 32'(fifo_pop[c]), 32'(e_pop[c]));
            end
            if (rst) begin
                rem[c] <= 0;
            end else if (e_pop[c]) begin
                rem[c]      <= flen(c);
                cur_byte[c] <= fifo_data[c];
            end else if (rem[c] > 0) begin
                rem[c] <= rem[c] - 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [7:0] b);
        fifo_mem[c][tail[c]] = b;
        tail[c] = tail[c] + 8'd1;
    endtask

    initial begin
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 256; i++) fifo_mem[c][i] = 8'h00;

        // reset, with a byte waiting on channel 0 that must not pop while reset is held
        tick(2);
        chk_en = 1'b1;
        push(0, 8'h55);
        tick(3);
        rst = 1'b0;
        tick(50);

        // idle with empty FIFOs
        tick(20);

        // back-to-back frames
        push(0, 8'hA5); push(0, 8'h00); push(0, 8'hFF);
        tick(130);

        // parity and two stop bits
        push(1, 8'h07); push(2, 8'h07);
        tick(60);

        // flow control: blocked, released, raised mid-frame
        cts_n[0] = 1'b1;
        push(0, 8'($urandom_range(0, 255)));
        tick(10);
        cts_n[0] = 1'b0;
        tick(10);
        cts_n[0] = 1'b1;
        push(0, 8'($urandom_range(0, 255)));
        tick(60);
        cts_n[0] = 1'b0;
        tick(50);

        // reset during data bit 3: the popped byte is lost, the next byte goes out cleanly
        push(0, 8'h3C); push(0, 8'hC3);
        tick(18);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(60);

        // random traffic and flow control on all channels
        for (int i = 0; i < 1500; i++) begin
            int c;
            c = $urandom_range(0, NCH - 1);
            if ($urandom_range(0, 29) == 0) push(c, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 19) == 0) cts_n[c] = ~cts_n[c];
            tick(1);
        end
        cts_n = '0;
        tick(600);

        for (int c = 0; c < NCH; c++)
            check($sformatf("drained%0d", c), 32'(head[c]), 32'(tail[c]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
